// File: rtl/mul_stage.sv
// -----------------------------------------------------------------------------
// mul_stage
// One handshaked FP16 (IEEE-754 half precision) multiply stage for the
// NeuroSpider neuron datapath. A single operand pair is accepted, multiplied
// over several clocks, and the product is held until the consumer takes it.
//
// Ports
//   clk                   in   1   single clock, rising edge
//   rst                   in   1   synchronous, active-high reset
//   srcReady              in   1   producer has valid in_A/in_B
//   readyForInput         out  1   stage can accept an operand pair (IDLE only)
//   in_A                  in   16  FP16 operand A
//   in_B                  in   16  FP16 operand B
//   outputReady           out  1   multiplicationResult is valid (OUT only)
//   destReady             in   1   consumer accepts the result
//   multiplicationResult  out  16  FP16 product A*B, registered
//   stateDebug            out  3   current FSM state, for observation only
//
// Handshake: an operand pair transfers on a rising edge where readyForInput
// and srcReady are both high; a result transfers on a rising edge where
// outputReady and destReady are both high. readyForInput and outputReady are
// decoded from the state and are never high together; srcReady/in_A/in_B are
// ignored outside IDLE and destReady is ignored outside OUT.
//
// Timing: accept on edge N, product registered on N+1, normalised on N+2,
// rounded result registered on N+3 (outputReady rises), handoff no earlier
// than N+4, next accept no earlier than N+5.
//
// Arithmetic: subnormal inputs and results are flushed to zero, rounding is
// round-to-nearest-even, overflow saturates to signed infinity, and every NaN
// result is the canonical quiet NaN 16'h7E00.
// -----------------------------------------------------------------------------
module mul_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        srcReady,
    output logic        readyForInput,
    input  logic [15:0] in_A,
    input  logic [15:0] in_B,
    output logic        outputReady,
    input  logic        destReady,
    output logic [15:0] multiplicationResult,
    output logic [2:0]  stateDebug
);

    // Rounding is split from normalisation into its own state (ROUND) so the
    // add-and-carry of the rounder does not sit behind the normalisation mux
    // in one cycle; this is also what gives the five-clock cadence.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        OUT   = 3'd4
    } stateT;

    localparam logic [15:0] CANON_NAN = 16'h7E00;

    stateT state;
    stateT nextState;

    // Captured operands
    logic [15:0] opA;
    logic [15:0] opB;

    // MUL-stage registers
    logic              mulSign;
    logic signed [7:0] mulExp;
    logic [21:0]       mulProd;
    logic              mulNaN;
    logic              mulInf;
    logic              mulZero;

    // NORM-stage registers
    logic [10:0]       normMant;
    logic              normGuard;
    logic              normSticky;
    logic signed [7:0] normExp;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        nextState     = state;
        readyForInput = 1'b0;
        outputReady   = 1'b0;
        case (state)
            IDLE: begin
                readyForInput = 1'b1;
                if (srcReady) begin
                    nextState = MUL;
                end
            end
            MUL:   nextState = NORM;
            NORM:  nextState = ROUND;
            ROUND: nextState = OUT;
            OUT: begin
                outputReady = 1'b1;
                if (destReady) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign stateDebug = state;

    // -------------------------------------------------------------------------
    // MUL stage: operand decode, special-case classification, raw product
    // -------------------------------------------------------------------------
    logic [4:0]        expA;
    logic [4:0]        expB;
    logic [9:0]        fracA;
    logic [9:0]        fracB;
    logic              nanA;
    logic              nanB;
    logic              infA;
    logic              infB;
    logic              zeroA;
    logic              zeroB;
    logic [10:0]       sigA;
    logic [10:0]       sigB;
    logic signed [7:0] expSum;
    logic [21:0]       prodRaw;

    always_comb begin
        expA  = opA[14:10];
        expB  = opB[14:10];
        fracA = opA[9:0];
        fracB = opB[9:0];

        nanA  = (expA == 5'h1F) && (fracA != 10'd0);
        nanB  = (expB == 5'h1F) && (fracB != 10'd0);
        infA  = (expA == 5'h1F) && (fracA == 10'd0);
        infB  = (expB == 5'h1F) && (fracB == 10'd0);
        // Exponent field zero covers both true zero and subnormals (flushed).
        zeroA = (expA == 5'd0);
        zeroB = (expB == 5'd0);

        sigA  = zeroA ? 11'd0 : {1'b1, fracA};
        sigB  = zeroB ? 11'd0 : {1'b1, fracB};

        // Unbiased sum re-biased once: range -13..45, fits signed 8 bits.
        expSum  = $signed({3'b000, expA}) + $signed({3'b000, expB}) - 8'sd15;
        prodRaw = {11'd0, sigA} * {11'd0, sigB};
    end

    // -------------------------------------------------------------------------
    // NORM stage: bring the product into [1,2) and extract guard/sticky.
    // The significand product of two normals lies in [2^20, 2^22), so at most
    // one right shift is needed.
    // -------------------------------------------------------------------------
    logic [10:0]       normMantNext;
    logic              normGuardNext;
    logic              normStickyNext;
    logic signed [7:0] normExpNext;

    always_comb begin
        if (mulProd[21]) begin
            normMantNext   = mulProd[21:11];
            normGuardNext  = mulProd[10];
            normStickyNext = |mulProd[9:0];
            normExpNext    = mulExp + 8'sd1;
        end else begin
            normMantNext   = mulProd[20:10];
            normGuardNext  = mulProd[9];
            normStickyNext = |mulProd[8:0];
            normExpNext    = mulExp;
        end
    end

    // -------------------------------------------------------------------------
    // ROUND stage: round-to-nearest-even, exponent range check, special-case
    // override and final assembly.
    // -------------------------------------------------------------------------
    logic              roundUp;
    logic [11:0]       mantRounded;
    logic signed [7:0] expRounded;
    logic [9:0]        fracOut;
    logic [15:0]       finalResult;

    always_comb begin
        // Round up when above halfway, or exactly halfway with an odd LSB.
        roundUp     = normGuard && (normSticky || normMant[0]);
        mantRounded = {1'b0, normMant} + {11'd0, roundUp};

        // A carry out of the rounder means the significand became 2.0:
        // renormalise by bumping the exponent; the fraction is then all zero.
        if (mantRounded[11]) begin
            expRounded = normExp + 8'sd1;
            fracOut    = mantRounded[10:1];
        end else begin
            expRounded = normExp;
            fracOut    = mantRounded[9:0];
        end

        if (mulNaN) begin
            finalResult = CANON_NAN;
        end else if (mulInf) begin
            finalResult = {mulSign, 5'h1F, 10'd0};
        end else if (mulZero) begin
            finalResult = {mulSign, 15'd0};
        end else if (expRounded >= 8'sd31) begin
            finalResult = {mulSign, 5'h1F, 10'd0};
        end else if (expRounded <= 8'sd0) begin
            finalResult = {mulSign, 15'd0};
        end else begin
            finalResult = {mulSign, expRounded[4:0], fracOut};
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers, each loaded only in the state that owns it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            opA                  <= 16'd0;
            opB                  <= 16'd0;
            mulSign              <= 1'b0;
            mulExp               <= 8'sd0;
            mulProd              <= 22'd0;
            mulNaN               <= 1'b0;
            mulInf               <= 1'b0;
            mulZero              <= 1'b0;
            normMant             <= 11'd0;
            normGuard            <= 1'b0;
            normSticky           <= 1'b0;
            normExp              <= 8'sd0;
            multiplicationResult <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (srcReady) begin
                        opA <= in_A;
                        opB <= in_B;
                    end
                end
                MUL: begin
                    mulSign <= opA[15] ^ opB[15];
                    mulExp  <= expSum;
                    mulProd <= prodRaw;
                    // Inf times zero (including flushed subnormals) is invalid.
                    mulNaN  <= nanA || nanB || (infA && zeroB) || (infB && zeroA);
                    mulInf  <= infA || infB;
                    mulZero <= zeroA || zeroB;
                end
                NORM: begin
                    normMant   <= normMantNext;
                    normGuard  <= normGuardNext;
                    normSticky <= normStickyNext;
                    normExp    <= normExpNext;
                end
                ROUND: begin
                    multiplicationResult <= finalResult;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_stage.sv
// -----------------------------------------------------------------------------
// tb_mul_stage
// Directed and randomized bench for mul_stage. Expected products come from a
// real-number reference: operands are decoded to their values, multiplied
// exactly in double precision, then re-encoded to FP16 with
// round-to-nearest-even, overflow to infinity and flush-to-zero.
// -----------------------------------------------------------------------------
module tb_mul_stage;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        srcReady;
    logic        readyForInput;
    logic [15:0] inA;
    logic [15:0] inB;
    logic        outputReady;
    logic        destReady;
    logic [15:0] multiplicationResult;
    logic [2:0]  stateDebug;

    always #5 clk = ~clk;

    mul_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .srcReady             (srcReady),
        .readyForInput        (readyForInput),
        .in_A                 (inA),
        .in_B                 (inB),
        .outputReady          (outputReady),
        .destReady            (destReady),
        .multiplicationResult (multiplicationResult),
        .stateDebug           (stateDebug)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) begin
            for (int i = 0; i < e; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -e; i++) r = r / 2.0;
        end
        return r;
    endfunction

    function automatic logic [15:0] refMul(input logic [15:0] a, input logic [15:0] b);
        logic sgn;
        int   ea, eb, e, biased, m;
        logic nanA, nanB, infA, infB, zA, zB;
        real  p, x, scaled, fl, rem;
        logic [15:0] res;
        sgn  = a[15] ^ b[15];
        ea   = int'(a[14:10]);
        eb   = int'(b[14:10]);
        nanA = (ea == 31) && (a[9:0] != 0);
        nanB = (eb == 31) && (b[9:0] != 0);
        infA = (ea == 31) && (a[9:0] == 0);
        infB = (eb == 31) && (b[9:0] == 0);
        zA   = (ea == 0);
        zB   = (eb == 0);
        if (nanA || nanB || (infA && zB) || (infB && zA)) return 16'h7E00;
        if (infA || infB) return {sgn, 5'h1F, 10'h000};
        if (zA || zB) return {sgn, 15'h0000};
        p = (1.0 + real'(a[9:0]) / 1024.0) * pow2(ea - 15)
          * (1.0 + real'(b[9:0]) / 1024.0) * pow2(eb - 15);
        x = p;
        e = 0;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0)  begin x = x * 2.0; e--; end
        scaled = x * 1024.0;
        fl     = $floor(scaled);
        rem    = scaled - fl;
        m      = int'(fl);
        if ((rem > 0.5) || ((rem == 0.5) && (m % 2 == 1))) m++;
        if (m == 2048) begin m = 1024; e++; end
        biased = e + 15;
        if (biased >= 31) return {sgn, 5'h1F, 10'h000};
        if (biased <= 0) return {sgn, 15'h0000};
        res = {sgn, biased[4:0], m[9:0]};
        return res;
    endfunction

    function automatic logic [15:0] randOperand();
        logic [15:0] specials [6];
        logic [4:0]  e;
        specials[0] = 16'h0000; specials[1] = 16'h8000; specials[2] = 16'h7C00;
        specials[3] = 16'hFC00; specials[4] = 16'h7E01; specials[5] = 16'h0155;
        if ($urandom_range(0, 9) == 0) return specials[$urandom_range(0, 5)];
        e = 5'($urandom_range(5, 25));
        return {1'($urandom_range(0, 1)), e, 10'($urandom_range(0, 1023))};
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge. Runs one operation with destReady low during
    // computation, holds the result for holdCycles, then consumes it.
    task automatic runOp(input logic [15:0] a, input logic [15:0] b,
                         input int holdCycles, input string tag);
        int waitCnt;
        logic [15:0] want;
        want    = refMul(a, b);
        waitCnt = 0;
        while (!readyForInput && waitCnt < 20) begin @(negedge clk); waitCnt++; end
        check({tag, ":idle"}, {15'd0, readyForInput}, 16'h0001);
        inA = a; inB = b; srcReady = 1'b1; destReady = 1'b0;
        @(negedge clk);
        srcReady = 1'b0;
        inA = 16'($urandom); inB = 16'($urandom);
        check({tag, ":rdyDrop"}, {15'd0, readyForInput}, 16'h0000);
        waitCnt = 0;
        while (!outputReady && waitCnt < 20) begin @(negedge clk); waitCnt++; end
        check({tag, ":latency"}, 16'(waitCnt), 16'd3);
        check({tag, ":result"}, multiplicationResult, want);
        for (int i = 0; i < holdCycles; i++) begin
            // Operand activity while holding must be ignored.
            srcReady = 1'b1; inA = 16'($urandom); inB = 16'($urandom);
            @(negedge clk);
            check({tag, ":holdValid"}, {15'd0, outputReady}, 16'h0001);
            check({tag, ":holdData"}, multiplicationResult, want);
        end
        srcReady  = 1'b0;
        destReady = 1'b1;
        @(negedge clk);
        destReady = 1'b0;
        check({tag, ":backIdle"}, {15'd0, readyForInput}, 16'h0001);
        check({tag, ":outLow"}, {15'd0, outputReady}, 16'h0000);
    endtask

    task automatic checkResetState(input string tag);
        check({tag, ":rdy"}, {15'd0, readyForInput}, 16'h0001);
        check({tag, ":out"}, {15'd0, outputReady}, 16'h0000);
        check({tag, ":res"}, multiplicationResult, 16'h0000);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int waitCnt;
        int lastOut;
        logic [15:0] a, b;

        rst = 1'b1; srcReady = 1'b0; destReady = 1'b0; inA = 16'h0; inB = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkResetState("reset");

        // Basic op with backpressure held for five cycles.
        runOp(16'h3C00, 16'h3C00, 5, "one");

        // Directed values, boundaries and specials.
        runOp(16'h4000, 16'h4200, 0, "two_x_three");
        runOp(16'hBE00, 16'h4000, 0, "neg");
        runOp(16'h3C01, 16'h3C01, 0, "rne");
        runOp(16'h7BFF, 16'h4000, 0, "overflow");
        runOp(16'h0400, 16'h0400, 0, "underflow");
        runOp(16'h8000, 16'h4000, 0, "negzero");
        runOp(16'h7C00, 16'h0000, 0, "inf_x_zero");
        runOp(16'h7E00, 16'h3C00, 0, "nan_in");
        runOp(16'hFC00, 16'h4000, 0, "neg_inf");
        runOp(16'h7C00, 16'h0200, 0, "inf_x_sub");
        runOp(16'h0200, 16'h4000, 0, "sub_flush");
        runOp(16'h3C00, 16'h3BFF, 0, "near_one");

        // Randomized operations.
        for (int n = 0; n < 30; n++) begin
            a = randOperand();
            b = randOperand();
            runOp(a, b, $urandom_range(0, 2), "rand");
        end

        // Reset while in MUL: leave a nonzero result first.
        runOp(16'h4000, 16'h4200, 0, "preRstMul");
        inA = 16'h3C00; inB = 16'h3C00; srcReady = 1'b1;
        @(negedge clk);
        srcReady = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkResetState("rstInMul");

        // Reset while in OUT holding a result.
        inA = 16'h4000; inB = 16'h4200; srcReady = 1'b1; destReady = 1'b0;
        @(negedge clk);
        srcReady = 1'b0;
        waitCnt = 0;
        while (!outputReady && waitCnt < 20) begin @(negedge clk); waitCnt++; end
        check("rstInOut:preResult", multiplicationResult, 16'h4600);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkResetState("rstInOut");
        runOp(16'hBE00, 16'h4000, 0, "postRst");

        // Back-to-back: srcReady and destReady held high, one result per 5 clocks.
        srcReady = 1'b1; destReady = 1'b1;
        lastOut = -1;
        for (int cyc = 0; cyc < 45; cyc++) begin
            if (outputReady) begin
                check("b2b:queued", {15'd0, exp_q.size() != 0}, 16'h0001);
                if (exp_q.size() != 0) check("b2b:result", multiplicationResult, exp_q.pop_front());
                if (lastOut >= 0) check("b2b:gap", 16'(cyc - lastOut), 16'd5);
                lastOut = cyc;
            end
            check("b2b:excl", {15'd0, readyForInput & outputReady}, 16'h0000);
            if (readyForInput) begin
                inA = randOperand();
                inB = randOperand();
                exp_q.push_back(refMul(inA, inB));
            end
            @(negedge clk);
        end
        srcReady = 1'b0;
        waitCnt = 0;
        while (exp_q.size() != 0 && waitCnt < 10) begin
            if (outputReady) check("b2b:drain", multiplicationResult, exp_q.pop_front());
            @(negedge clk);
            waitCnt++;
        end
        check("b2b:drained", 16'(exp_q.size()), 16'd0);
        destReady = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
